serial_word_adder: RTL and testbench

SERIAL_WORD_ADDER -- requirements
Module: serial_word_adder

---
 rtl/serial_add_pkg.sv | 12 +
 rtl/byte_add_slice.sv | 14 +
 rtl/serial_word_adder.sv | 117 +++++++++++
 tb/tb_serial_word_adder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the byte-serial word adder.
package serial_add_pkg;

  localparam int BYTE_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/byte_add_slice.sv
// One BYTE_W-wide combinational add slice with carry in and carry out.
module byte_add_slice #(
  parameter int BYTE_W = serial_add_pkg::BYTE_W_DEFAULT
) (
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              ci,
  output logic [BYTE_W-1:0] s,
  output logic              co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, ci};

endmodule

// File: rtl/serial_word_adder.sv
// Adds two NBYTES-wide unsigned words one byte per cycle through a single slice,
// with a valid/ready handshake on both the operand and the result side.
module serial_word_adder
  import serial_add_pkg::*;
#(
  parameter int NBYTES = 4,
  parameter int BYTE_W = BYTE_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NBYTES*BYTE_W-1:0] a,
  input  logic [NBYTES*BYTE_W-1:0] b,
  input  logic                     cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NBYTES*BYTE_W-1:0] sum,
  output logic                     cout
);

  localparam int WORD_W = NBYTES * BYTE_W;
  localparam int IDX_W  = $clog2(NBYTES) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t            state_reg, state_next;
  logic              in_ready_reg;
  logic [WORD_W-1:0] a_reg, b_reg, sum_reg, sum_next;
  logic              carry_reg, cout_reg;
  logic [IDX_W-1:0]  idx_reg;

  logic [BYTE_W-1:0] a_mask [NBYTES];
  logic [BYTE_W-1:0] b_mask [NBYTES];
  logic [BYTE_W-1:0] a_byte, b_byte, slice_s;
  logic              slice_co;
  logic              accept, run_last;

  // Byte select is a masked OR so idx never drives a variable part-select.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
    assign a_mask[gi] = (idx_reg == IDX_W'(gi)) ? a_reg[gi*BYTE_W +: BYTE_W] : '0;
    assign b_mask[gi] = (idx_reg == IDX_W'(gi)) ? b_reg[gi*BYTE_W +: BYTE_W] : '0;
    assign sum_next[gi*BYTE_W +: BYTE_W] =
      (idx_reg == IDX_W'(gi)) ? slice_s : sum_reg[gi*BYTE_W +: BYTE_W];
  end

  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      a_byte = a_byte | a_mask[i];
      b_byte = b_byte | b_mask[i];
    end
  end

  byte_add_slice #(
    .BYTE_W(BYTE_W)
  ) u_slice (
    .a  (a_byte),
    .b  (b_byte),
    .ci (carry_reg),
    .s  (slice_s),
    .co (slice_co)
  );

  assign accept   = in_valid && in_ready_reg;
  assign run_last = (idx_reg == LAST_IDX);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (run_last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      in_ready_reg <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      sum_reg      <= '0;
      carry_reg    <= 1'b0;
      cout_reg     <= 1'b0;
      idx_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      // Registered so ready only rises on the first edge out of reset.
      in_ready_reg <= (state_next == IDLE);
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx_reg   <= '0;
          end
        end
        RUN: begin
          sum_reg   <= sum_next;
          carry_reg <= slice_co;
          idx_reg   <= idx_reg + IDX_W'(1);
          if (run_last) cout_reg <= slice_co;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = (state_reg == DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;

endmodule

// File: tb/tb_serial_word_adder.sv
// Bench for serial_word_adder: NBYTES=4 and NBYTES=1 instances share stimulus and
// are both checked every cycle against a cycle-count/arithmetic reference model.
module tb_serial_word_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, cin;
  logic [31:0] a, b;

  logic        in_ready4, out_valid4, cout4;
  logic [31:0] sum4;
  logic        in_ready1, out_valid1, cout1;
  logic [7:0]  sum1;

  always #5 clk = ~clk;

  serial_word_adder #(.NBYTES(4), .BYTE_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid4), .out_ready(out_ready),
    .sum(sum4), .cout(cout4)
  );

  serial_word_adder #(.NBYTES(1), .BYTE_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .out_valid(out_valid1), .out_ready(out_ready),
    .sum(sum1), .cout(cout1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    else
      n_pass++;
  endtask

  // ---------------- reference model: protocol by cycle counts, result by arithmetic
  logic         ir_w [2];
  logic         ov_w [2];
  logic         co_w [2];
  logic [127:0] s_w  [2];
  assign ir_w[0] = in_ready4;   assign ir_w[1] = in_ready1;
  assign ov_w[0] = out_valid4;  assign ov_w[1] = out_valid1;
  assign co_w[0] = cout4;       assign co_w[1] = cout1;
  assign s_w[0]  = {96'd0, sum4};
  assign s_w[1]  = {120'd0, sum1};

  // phase: 0 = first cycle out of reset, 1 = idle, 2 = busy, 3 = result held
  int           phase    [2] = '{0, 0};
  int           busy_cnt [2] = '{0, 0};
  int           done_cnt [2] = '{0, 0};
  logic [127:0] exp_sum  [2];
  logic         exp_cout [2];
  int           m_nb;
  logic [127:0] m_mask, m_full;
  string        tag;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      m_nb   = (k == 0) ? 4 : 1;
      m_mask = (128'd1 << (8 * m_nb)) - 128'd1;
      tag    = $sformatf("n%0d", m_nb);
      if (!rst_n || phase[k] == 0) begin
        check({tag, "_rst_ready"}, 128'(ir_w[k]), 128'd0);
        check({tag, "_rst_valid"}, 128'(ov_w[k]), 128'd0);
        check({tag, "_rst_sum"},   s_w[k],        128'd0);
        check({tag, "_rst_cout"},  128'(co_w[k]), 128'd0);
        phase[k] = rst_n ? 1 : 0;
      end else begin
        case (phase[k])
          1: begin
            check({tag, "_idle_ready"}, 128'(ir_w[k]), 128'd1);
            check({tag, "_idle_valid"}, 128'(ov_w[k]), 128'd0);
            if (in_valid) begin
              m_full = ({96'd0, a} & m_mask) + ({96'd0, b} & m_mask) + 128'(cin);
              exp_sum[k]  = m_full & m_mask;
              exp_cout[k] = |(m_full & ~m_mask);
              busy_cnt[k] = m_nb;
              phase[k]    = 2;
            end
          end
          2: begin
            check({tag, "_busy_ready"}, 128'(ir_w[k]), 128'd0);
            check({tag, "_busy_valid"}, 128'(ov_w[k]), 128'd0);
            busy_cnt[k]--;
            if (busy_cnt[k] == 0) phase[k] = 3;
          end
          default: begin
            check({tag, "_done_ready"}, 128'(ir_w[k]), 128'd0);
            check({tag, "_done_valid"}, 128'(ov_w[k]), 128'd1);
            check({tag, "_done_sum"},   s_w[k],        exp_sum[k]);
            check({tag, "_done_cout"},  128'(co_w[k]), 128'(exp_cout[k]));
            if (out_ready) begin
              phase[k] = 1;
              done_cnt[k]++;
            end
          end
        endcase
      end
    end
  end

  // ---------------- directed helpers (NBYTES=4 instance)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic cv);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    cin      = cv;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready4) ok = 1'b1;
    end
    check("accept_timeout", 128'(ok), 128'd1);
    tick();
    // Scramble operands right after acceptance; the result must not change.
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    cin      = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid4) break;
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0000_0000;
      2:       return 32'h0000_00FF;
      default: return $urandom;
    endcase
  endfunction

  int lat;
  int seen_valid;
  int cycles;
  int d0, d1;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    repeat (3) tick();
    check("reset_ready_low", 128'(in_ready4), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_low_before_first_edge", 128'(in_ready4), 128'd0);
    tick();
    check("ready_high_after_first_edge", 128'(in_ready4), 128'd1);

    // carry across one byte boundary, and exact latency
    start_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
    wait_valid(lat);
    check("lat_ff_plus_1", 128'(lat), 128'd5);
    check("sum_ff_plus_1", 128'(sum4), 128'h0000_0100);
    check("cout_ff_plus_1", 128'(cout4), 128'd0);
    tick();

    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_valid(lat);
    check("sum_max_max_c", 128'(sum4), 128'hFFFF_FFFF);
    check("cout_max_max_c", 128'(cout4), 128'd1);
    tick();

    // full ripple through every byte
    start_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    wait_valid(lat);
    check("sum_ripple", 128'(sum4), 128'h0);
    check("cout_ripple", 128'(cout4), 128'd1);
    tick();

    // result held under back-pressure while inputs toggle
    out_ready = 1'b0;
    start_op(32'hDEAD_BEEF, 32'h0102_0304, 1'b1);
    wait_valid(lat);
    check("lat_stall", 128'(lat), 128'd5);
    for (int i = 0; i < 3; i++) begin
      tick();
      in_valid = ~in_valid;
      a        = $urandom;
      @(negedge clk);
      check("stall_ready", 128'(in_ready4), 128'd0);
      check("stall_sum", 128'(sum4), 128'hDFAF_C1F4);
      check("stall_cout", 128'(cout4), 128'd0);
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_release_valid", 128'(out_valid4), 128'd1);
    tick();
    @(negedge clk);
    check("idle_after_release_valid", 128'(out_valid4), 128'd0);
    check("idle_after_release_ready", 128'(in_ready4), 128'd1);
    tick();

    // reset in the middle of RUN at idx=2
    start_op(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrun_rst_ready", 128'(in_ready4), 128'd0);
    check("midrun_rst_valid", 128'(out_valid4), 128'd0);
    check("midrun_rst_sum", 128'(sum4), 128'd0);
    check("midrun_rst_cout", 128'(cout4), 128'd0);
    tick();
    rst_n      = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid4) seen_valid++;
    end
    check("no_valid_after_rst", 128'(seen_valid), 128'd0);
    tick();
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_valid(lat);
    check("sum_after_rst", 128'(sum4), 128'h2345_6789);
    check("cout_after_rst", 128'(cout4), 128'd0);
    tick();

    // random back-to-back traffic with stalls; both widths checked by the model
    d0     = done_cnt[0];
    d1     = done_cnt[1];
    cycles = 0;
    while ((done_cnt[0] - d0 < 1000 || done_cnt[1] - d1 < 1000) && cycles < 40000) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      a         = pick_operand();
      b         = pick_operand();
      cin       = 1'($urandom_range(0, 1));
      tick();
      cycles++;
    end
    check("random_budget", 128'(cycles < 40000), 128'd1);

    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
